// File: rtl/branch_resolve_unit.sv
// Registered branch resolution: condition, target, mispredict check and
// wrap-around branch/mispredict statistics for the performance monitor.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  operand_a_i,
  input  logic [XLEN-1:0]  operand_b_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  input  logic             clr_cnt_i,
  output logic             valid_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic [1:0] {
    K_NONE,
    K_BR,
    K_JAL,
    K_JALR
  } kind_e;

  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  logic [4:0] opc;
  logic [2:0] f3;
  logic       unused_instr;

  assign opc = instr_i[6:2];
  assign f3  = instr_i[14:12];
  assign unused_instr = ^{instr_i[31:15], instr_i[11:7], instr_i[1:0]};

  kind_e kind;

  always_comb begin
    kind = K_NONE;
    unique case (opc)
      OP_BR:   kind = K_BR;
      OP_JAL:  kind = K_JAL;
      OP_JALR: kind = K_JALR;
      default: kind = K_NONE;
    endcase
  end

  logic is_ctrl;
  assign is_ctrl = (kind != K_NONE);

  logic eq;
  logic lt_u;
  logic lt_s;
  logic lt;

  assign eq   = (operand_a_i == operand_b_i);
  assign lt_u = (operand_a_i < operand_b_i);
  // Differing sign bits decide the signed order outright.
  assign lt_s = (operand_a_i[XLEN-1] != operand_b_i[XLEN-1])
              ? operand_a_i[XLEN-1] : lt_u;
  assign lt   = f3[1] ? lt_u : lt_s;

  logic cond;

  always_comb begin
    cond = 1'b0;
    unique case (f3)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100,
      3'b110:  cond = lt;
      3'b101,
      3'b111:  cond = eq | ~lt;
      default: cond = 1'b0;
    endcase
  end

  logic            taken;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] a_imm;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;

  assign pc_imm   = pc_i + imm_i;
  assign a_imm    = operand_a_i + imm_i;
  assign pc_plus4 = pc_i + XLEN'(4);

  always_comb begin
    taken  = 1'b0;
    target = pc_imm;
    unique case (kind)
      K_BR:    taken = cond;
      K_JAL:   taken = 1'b1;
      K_JALR: begin
        taken  = 1'b1;
        target = {a_imm[XLEN-1:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  logic            mispred;
  logic [XLEN-1:0] redirect;

  assign redirect = taken ? target : pc_plus4;
  assign mispred  = (taken != pred_taken_i)
                  | (taken & pred_taken_i & (target != pred_target_i));

  logic acc;
  assign acc = valid_i & ~flush_i;

  logic             valid_q;
  logic             taken_q;
  logic             mispred_q;
  logic [XLEN-1:0]  redirect_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] bcnt_d;
  logic [CNT_W-1:0] mcnt_q;
  logic [CNT_W-1:0] mcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (clr_cnt_i) begin
      bcnt_d = '0;
      mcnt_d = '0;
    end else if (acc) begin
      if (is_ctrl) bcnt_d = bcnt_q + CNT_W'(1);
      if (mispred) mcnt_d = mcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      mispred_q  <= 1'b0;
      redirect_q <= '0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      valid_q   <= acc;
      taken_q   <= acc & taken;
      mispred_q <= acc & mispred;
      if (acc) redirect_q <= redirect;
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign valid_o       = valid_q;
  assign taken_o       = taken_q;
  assign mispredict_o  = mispred_q;
  assign redirect_pc_o = redirect_q;
  assign branch_cnt_o  = bcnt_q;
  assign mispred_cnt_o = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus random
// traffic checked against an arithmetic reference model.
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             valid_i;
  logic             flush_i;
  logic [31:0]      instr_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  operand_a_i;
  logic [XLEN-1:0]  operand_b_i;
  logic [XLEN-1:0]  imm_i;
  logic             pred_taken_i;
  logic [XLEN-1:0]  pred_target_i;
  logic             clr_cnt_i;
  logic             valid_o;
  logic             taken_o;
  logic             mispredict_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .valid_i(valid_i),
    .flush_i(flush_i),
    .instr_i(instr_i),
    .pc_i(pc_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .imm_i(imm_i),
    .pred_taken_i(pred_taken_i),
    .pred_target_i(pred_target_i),
    .clr_cnt_i(clr_cnt_i),
    .valid_o(valid_o),
    .taken_o(taken_o),
    .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o),
    .branch_cnt_o(branch_cnt_o),
    .mispred_cnt_o(mispred_cnt_o)
  );

  typedef struct {
    bit        valid;
    bit        taken;
    bit        mis;
    bit [31:0] redir;
    int        bcnt;
    int        mcnt;
    string     tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference state
  int        m_bcnt = 0;
  int        m_mcnt = 0;
  bit [31:0] m_redir = 0;

  function automatic bit [31:0] mk(input bit [4:0] opc, input bit [2:0] f3);
    return {17'h0, f3, 5'h0, opc, 2'b11};
  endfunction

  function automatic void chk(input string name, input longint act,
                              input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic step(input bit rst, input bit v, input bit fl,
                      input bit [31:0] ins, input bit [31:0] pc,
                      input bit [31:0] a, input bit [31:0] b,
                      input bit [31:0] imm, input bit pt,
                      input bit [31:0] ptgt, input bit clr,
                      input string tag);
    bit [4:0] opc;
    bit [2:0] f3;
    bit ctrl, tk, mis, acc;
    longint sa, sb, ua, ub, tgt;
    bit [31:0] redir;
    exp_t e;
    @(negedge clk);
    rst_ni = ~rst; valid_i = v; flush_i = fl; instr_i = ins; pc_i = pc;
    operand_a_i = a; operand_b_i = b; imm_i = imm; pred_taken_i = pt;
    pred_target_i = ptgt; clr_cnt_i = clr;
    opc = ins[6:2];
    f3  = ins[14:12];
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a); ub = longint'(b);
    ctrl = (opc == 5'b11000) || (opc == 5'b11011) || (opc == 5'b11001);
    tk = 0;
    tgt = (longint'(pc) + longint'(imm)) % 64'h1_0000_0000;
    if (opc == 5'b11000) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = (sa < sb);
        3'd5: tk = (sa >= sb);
        3'd6: tk = (ua < ub);
        3'd7: tk = (ua >= ub);
        default: tk = 0;
      endcase
    end else if (opc == 5'b11011) begin
      tk = 1;
    end else if (opc == 5'b11001) begin
      tk = 1;
      tgt = ((longint'(a) + longint'(imm)) % 64'h1_0000_0000) / 2 * 2;
    end
    redir = tk ? 32'(tgt) : 32'((longint'(pc) + 4) % 64'h1_0000_0000);
    mis = (tk != pt) || (tk && pt && (32'(tgt) != ptgt));
    acc = v && !fl;
    e.tag = tag;
    if (rst) begin
      m_bcnt = 0; m_mcnt = 0; m_redir = 0;
      e.valid = 0; e.taken = 0; e.mis = 0;
    end else begin
      if (clr) begin
        m_bcnt = 0; m_mcnt = 0;
      end else if (acc) begin
        if (ctrl) m_bcnt = (m_bcnt + 1) % 16;
        if (mis)  m_mcnt = (m_mcnt + 1) % 16;
      end
      if (acc) m_redir = redir;
      e.valid = acc; e.taken = acc && tk; e.mis = acc && mis;
    end
    e.redir = m_redir; e.bcnt = m_bcnt; e.mcnt = m_mcnt;
    q.push_back(e);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, mk(5'b01100, 0), 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // monitor: one expectation per edge, compared after the edge settles
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.tag, ".valid"}, valid_o, e.valid);
        chk({e.tag, ".bcnt"}, branch_cnt_o, e.bcnt);
        chk({e.tag, ".mcnt"}, mispred_cnt_o, e.mcnt);
        chk({e.tag, ".taken"}, taken_o, e.taken);
        chk({e.tag, ".mis"}, mispredict_o, e.mis);
        chk({e.tag, ".redir"}, redirect_pc_o, e.redir);
      end
    end
  end

  localparam bit [4:0] BR = 5'b11000, JAL = 5'b11011, JALR = 5'b11001;
  localparam bit [4:0] ADD = 5'b01100;

  initial begin
    bit [4:0] ops [5];
    bit [4:0] o;
    bit [31:0] a, b, pc, imm, ptgt;
    ops[0] = BR; ops[1] = JAL; ops[2] = JALR; ops[3] = ADD; ops[4] = 5'b01101;
    rst_ni = 0; valid_i = 0; flush_i = 0; instr_i = 0; pc_i = 0;
    operand_a_i = 0; operand_b_i = 0; imm_i = 0; pred_taken_i = 0;
    pred_target_i = 0; clr_cnt_i = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
    step(1, 1, 0, mk(JAL, 0), 32'h40, 0, 0, 8, 0, 0, 0, "reset1");
    idle("idle0");

    step(0, 1, 0, mk(BR, 3'd4), 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 0, 0, 0,
         "blt");
    step(0, 1, 0, mk(BR, 3'd6), 32'h100, 32'hFFFF_FFFF, 1, 32'h20, 0, 0, 0,
         "bltu");
    step(0, 1, 0, mk(JALR, 0), 32'h500, 32'h1003, 0, 4, 1, 32'h1006, 0,
         "jalr_ok");
    step(0, 1, 0, mk(JALR, 0), 32'h500, 32'h1003, 0, 4, 1, 32'h1000, 0,
         "jalr_bad");
    step(0, 1, 0, mk(ADD, 0), 32'h200, 5, 6, 0, 1, 32'h999, 0, "add_pt");
    step(0, 1, 0, mk(BR, 3'd2), 32'h300, 1, 1, 16, 1, 32'h310, 0, "f3_010");
    step(0, 1, 1, mk(BR, 3'd0), 32'h300, 7, 7, 16, 0, 0, 0, "flush_v");
    step(0, 0, 1, mk(BR, 3'd0), 32'h300, 7, 7, 16, 0, 0, 0, "flush_nv");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "clr");
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, mk(BR, 3'd1), 32'h400 + 4 * i, i, 9, 8, 1,
           32'h408 + 4 * i, 0, "bne_seq");
    idle("idle1");

    // wrap: 16 accepted branches return the 4-bit counter to its start
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "clr2");
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, mk(BR, 3'd5), 32'h800, 32'h8000_0000, 0, 12, 0, 0, 0,
           "wrap");
    step(0, 1, 0, mk(BR, 3'd0), 32'h900, 3, 3, 64, 0, 0, 1, "clr_mis");
    step(0, 1, 0, mk(JAL, 0), 32'hA00, 0, 0, 32'hFFFF_FFF0, 0, 0, 0,
         "jal_neg");

    step(1, 1, 0, mk(JAL, 0), 32'hB00, 0, 0, 4, 0, 0, 1, "rst_mid");
    step(0, 1, 0, mk(BR, 3'd7), 32'hC00, 0, 32'hFFFF_FFFF, 4, 0, 0, 0,
         "post_rst");
    idle("idle2");

    for (int i = 0; i < 400; i++) begin
      o   = ops[$urandom_range(0, 4)];
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], b[30:0]};
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom)))
                                         : $urandom;
      ptgt = ($urandom_range(0, 1) == 0) ? pc + imm : $urandom;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) == 0, mk(o, 3'($urandom)), pc, a, b, imm,
           1'($urandom), ptgt, $urandom_range(0, 29) == 0, "rand");
    end
    idle("tail");

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
